// File: rtl/sfm_stream_framer.sv
// Frames a BF16 stream into softmax jobs: counts beats, flags the final beat and
// pads its unused trailing lanes with a neutral fill value.
module sfm_stream_framer #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ELEM_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 32,
   parameter logic [ELEM_WIDTH-1:0] FILL_VALUE = 16'hFF80
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [LEN_WIDTH-1:0]    length_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [DATA_WIDTH-1:0]   in_data_i,
   input  logic [DATA_WIDTH/8-1:0] in_strb_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic [DATA_WIDTH/8-1:0] out_strb_o,
   output logic                    last_o,
   output logic                    busy_o,
   output logic                    done_o
);
   // state | meaning
   // IDLE  | waiting for start_i
   // RUN   | accepting input beats
   // DRAIN | final beat held, waiting for its output handshake
   // DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int unsigned NLANES     = DATA_WIDTH / ELEM_WIDTH;
   localparam int unsigned LANE_BITS  = $clog2(NLANES);
   localparam int unsigned LANE_BYTES = ELEM_WIDTH / 8;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   state_t                  state;
   logic [LEN_WIDTH-1:0]    beat_cnt;
   logic [LEN_WIDTH:0]      beats_last;
   logic [LANE_BITS-1:0]    tail;
   logic [LEN_WIDTH:0]      total_calc;
   logic                    is_final;
   logic                    in_hs;
   logic                    out_hs;
   logic [DATA_WIDTH-1:0]   masked_data;
   logic [STRB_WIDTH-1:0]   masked_strb;
   logic                    unused_strb;

   assign unused_strb = ^in_strb_i;

   // One extra bit keeps the round-up free of overflow at the maximum length.
   assign total_calc = ({1'b0, length_i} + (LEN_WIDTH+1)'(NLANES - 1)) >> LANE_BITS;
   assign is_final   = ({1'b0, beat_cnt} == beats_last);
   assign in_ready_o = (state == RUN) && (!out_valid_o || out_ready_i);
   assign in_hs      = in_valid_i && in_ready_o;
   assign out_hs     = out_valid_o && out_ready_i;

   always_comb begin
      masked_data = in_data_i;
      masked_strb = '1;
      if (is_final && tail != '0) begin
         for (int i = 0; i < NLANES; i++) begin
            if (i >= int'(tail)) begin
               masked_data[i*ELEM_WIDTH +: ELEM_WIDTH] = FILL_VALUE;
               masked_strb[i*LANE_BYTES +: LANE_BYTES] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         beats_last  <= '0;
         tail        <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_strb_o  <= '0;
         last_o      <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (length_i == '0) begin
                     done_o <= 1'b1;
                     state  <= DONE;
                  end else begin
                     beats_last <= total_calc - 1'b1;
                     tail       <= length_i[LANE_BITS-1:0];
                     beat_cnt   <= '0;
                     busy_o     <= 1'b1;
                     state      <= RUN;
                  end
               end
            end
            RUN: begin
               if (in_hs) begin
                  out_valid_o <= 1'b1;
                  out_data_o  <= masked_data;
                  out_strb_o  <= masked_strb;
                  last_o      <= is_final;
                  beat_cnt    <= beat_cnt + 1'b1;
                  if (is_final) state <= DRAIN;
               end else if (out_hs) begin
                  out_valid_o <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  out_valid_o <= 1'b0;
                  last_o      <= 1'b0;
                  busy_o      <= 1'b0;
                  done_o      <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               done_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sfm_stream_framer.sv
// Bench for sfm_stream_framer: a queue model of framed beats checked every
// cycle, plus literal expectations for the directed jobs.
module tb_sfm_stream_framer;
   localparam int DW = 256;
   localparam int SW = 32;
   localparam int NL = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clear = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   length = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [SW-1:0] in_strb = 32'hA5A5_5A5A;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [SW-1:0] out_strb;
   logic          last;
   logic          busy;
   logic          done;

   sfm_stream_framer dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .length_i(length),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_strb_i(in_strb),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_strb_o(out_strb), .last_o(last), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   beat_t q[$];
   bit    job_active = 0, pending_done = 0, zero_flag = 0;
   int    beats_in = 0, total = 0, job_len = 0;
   int    done_cnt = 0, hs_cnt = 0, last_cnt = 0, ready_seen = 0, busy_seen = 0;
   int    rdy_mode = 0;
   logic [DW-1:0] cap_data, last_fed;
   logic [SW-1:0] cap_strb;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   function automatic beat_t make_beat(input logic [DW-1:0] d, input int k, input int len, input int tot);
      beat_t b;
      int t;
      b.data = d;
      b.strb = '1;
      b.last = (k == tot - 1);
      t = len % NL;
      if (b.last && t != 0) begin
         for (int l = t; l < NL; l++) begin
            b.data[l*16 +: 16] = 16'hFF80;
            b.strb[l*2 +: 2]   = 2'b00;
         end
      end
      return b;
   endfunction

   function automatic logic [DW-1:0] gen_data(input int tag);
      logic [DW-1:0] d;
      for (int l = 0; l < NL; l++) d[l*16 +: 16] = 16'(tag * 16 + l + 256);
      return d;
   endfunction

   // Model step: outputs are compared on every falling edge, then the
   // handshakes the next rising edge will perform are applied to the model.
   bit    exp_done, exp_valid, exp_ready, hs_in, hs_out;
   beat_t fb;
   always @(negedge clk) begin
      exp_done     = pending_done | zero_flag;
      pending_done = 0;
      zero_flag    = 0;
      if (exp_done) job_active = 0;
      exp_valid = (q.size() != 0);
      exp_ready = job_active && (beats_in < total) && (!exp_valid || out_ready);
      check_bit("done", done, exp_done);
      check_bit("busy", busy, job_active);
      check_bit("in_ready", in_ready, exp_ready);
      check_bit("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         fb = q[0];
         check("out_data", out_data, fb.data);
         check("out_strb", DW'(out_strb), DW'(fb.strb));
         check_bit("last", last, fb.last);
      end
      if (done === 1'b1) done_cnt++;
      if (in_ready === 1'b1) ready_seen++;
      if (busy === 1'b1) busy_seen++;
      hs_out = exp_valid && out_ready;
      hs_in  = in_valid && exp_ready;
      if (hs_out) begin
         fb = q.pop_front();
         pending_done = fb.last;
         hs_cnt++;
         if (fb.last) begin
            last_cnt++;
            cap_data = out_data;
            cap_strb = out_strb;
         end
      end
      if (hs_in) begin
         q.push_back(make_beat(in_data, beats_in, job_len, total));
         beats_in++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic start_job(input int len);
      start  = 1'b1;
      length = len;
      @(posedge clk);
      if (len == 0) zero_flag = 1;
      else begin
         job_active = 1;
         job_len    = len;
         total      = (len + NL - 1) / NL;
         beats_in   = 0;
      end
      #1 start = 1'b0;
   endtask

   task automatic feed(input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         int cyc;
         in_valid = 1'b1;
         in_data  = gen_data(k + job_len);
         last_fed = in_data;
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (in_ready !== 1'b1 && cyc < 200);
         if (cyc >= 200) timeout("feed");
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while ((job_active || q.size() != 0 || pending_done || zero_flag) && cyc < 300);
      if (cyc >= 300) timeout("wait_idle");
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst       = 1'b1;
      in_valid  = 1'b0;
      rdy_mode  = 2;
      out_ready = 1'b0;
      @(posedge clk);
      q.delete();
      job_active   = 0;
      pending_done = 0;
      zero_flag    = 0;
      beats_in     = 0;
      total        = 0;
      #1;
      rst       = 1'b0;
      rdy_mode  = 0;
      out_ready = 1'b1;
   endtask

   int h0, l0, d0, r0, b0;
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_bit("rst_valid", out_valid, 1'b0);
      check_bit("rst_ready", in_ready, 1'b0);
      check_bit("rst_last", last, 1'b0);
      check("rst_data", out_data, '0);
      check("rst_strb", DW'(out_strb), '0);
      @(posedge clk);
      #1 rst = 1'b0;

      // two full beats
      h0 = hs_cnt; l0 = last_cnt; d0 = done_cnt;
      start_job(32);
      feed(0, 2);
      wait_idle();
      check_int("len32_beats", hs_cnt - h0, 2);
      check_int("len32_lasts", last_cnt - l0, 1);
      check_int("len32_done", done_cnt - d0, 1);
      check("len32_strb", DW'(cap_strb), DW'(32'hFFFF_FFFF));

      // partial tail of four lanes
      start_job(20);
      feed(0, 2);
      wait_idle();
      check("len20_strb", DW'(cap_strb), DW'(32'h0000_00FF));
      check("len20_fill", DW'(cap_data[DW-1:64]), DW'({12{16'hFF80}}));
      check("len20_lanes", DW'(cap_data[63:0]), DW'(last_fed[63:0]));

      // zero-length job
      r0 = ready_seen; b0 = busy_seen; d0 = done_cnt;
      start_job(0);
      wait_idle();
      check_int("len0_ready", ready_seen - r0, 0);
      check_int("len0_busy", busy_seen - b0, 0);
      check_int("len0_done", done_cnt - d0, 1);

      // random backpressure
      h0 = hs_cnt; l0 = last_cnt;
      rdy_mode = 1;
      start_job(64);
      feed(0, 4);
      wait_idle();
      rdy_mode  = 0;
      out_ready = 1'b1;
      check_int("len64_beats", hs_cnt - h0, 4);
      check_int("len64_lasts", last_cnt - l0, 1);

      // start ignored while running
      h0 = hs_cnt; d0 = done_cnt;
      start_job(48);
      feed(0, 1);
      start  = 1'b1;
      length = 1;
      @(posedge clk);
      #1 start = 1'b0;
      feed(1, 2);
      wait_idle();
      check_int("ignstart_beats", hs_cnt - h0, 3);
      check_int("ignstart_done", done_cnt - d0, 1);

      // reset mid-job
      d0 = done_cnt;
      start_job(64);
      feed(0, 2);
      reset_pulse();
      @(negedge clk);
      check_bit("midrst_valid", out_valid, 1'b0);
      check_bit("midrst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      check_int("midrst_nodone", done_cnt - d0, 0);
      @(posedge clk);
      #1;
      l0 = last_cnt; d0 = done_cnt;
      start_job(16);
      feed(0, 1);
      wait_idle();
      check_int("after_rst_lasts", last_cnt - l0, 1);
      check_int("after_rst_done", done_cnt - d0, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sfm_stream_framer.md
# sfm_stream_framer

Framing stage between the load streamer's input stream and the softmax datapath. It accepts a vector length per job and counts incoming DATA_WIDTH beats. It marks the final beat with `last` and overwrites the unused trailing lanes of that beat with a neutral fill value, so downstream max/sum reductions see only valid elements. It holds one output register, supports full throughput and backpressure, and reports job completion.

## Interface
- DATA_WIDTH, 256, stream data width in bits; must be a multiple of ELEM_WIDTH.
- ELEM_WIDTH, 16, element width (BF16).
- LEN_WIDTH, 32, width of the vector-length field.
- FILL_VALUE, 16'hFF80, value written into masked lanes (BF16 −inf).
- Derived: NLANES = DATA_WIDTH/ELEM_WIDTH (16 at defaults).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; identical effect to rst_i.
- start_i  in  1  job start pulse; sampled only in IDLE.
- length_i  in  LEN_WIDTH  vector length in elements; sampled with start_i.
- in_stream_i  sink  hwpe_stream_intf_stream (DATA_WIDTH)  beats from the load streamer; incoming strb is ignored.
- out_stream_o  source  hwpe_stream_intf_stream (DATA_WIDTH)  framed beats to the datapath; strb is a byte mask of valid lanes.
- last_o  out  1  high together with out_stream_o.valid on the final beat of a job.
- busy_o  out  1  high from start acceptance until done_o.
- done_o  out  1  one-cycle pulse at job completion.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_stream_i.ready = 0.
  - start_i=1 with length_i≠0: latch beats_total = ceil(length_i/NLANES) and tail = length_i mod NLANES (0 means full beat); clear beat_cnt; go to RUN.
  - start_i=1 with length_i=0: go directly to DONE; no beats are consumed.
- RUN:
  - in_stream_i.ready = ~out_valid | out_stream_o.ready.
  - Each input handshake loads the output register and increments beat_cnt.
  - The handshake with beat_cnt == beats_total−1 is the final beat:
    - set last;
    - if tail≠0, lanes ≥ tail get FILL_VALUE and their strb bytes go to 0;
    - go to DRAIN.
- DRAIN: in_stream_i.ready = 0; wait for the output handshake of the final beat, then go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- start_i outside IDLE is ignored; it has no effect on latched length or counters.
- Non-final beats pass unchanged with strb all-ones.
- Lane i occupies bits [i*ELEM_WIDTH +: ELEM_WIDTH], lane 0 at the LSB.
- beat_cnt is LEN_WIDTH wide.
- beats_total is computed as (length_i + NLANES−1) >> log2(NLANES) in LEN_WIDTH+1 bits, so there is no overflow at maximum length.

## Timing
- Reset/clear values:
  - state IDLE;
  - out_stream_o.valid 0, last_o 0, busy_o 0, done_o 0, in_stream_i.ready 0;
  - output data and strb 0.
- rst_i/clear_i mid-job: the next cycle is IDLE; the held beat is dropped; done_o is not pulsed.
- Start latency: start_i accepted at cycle t → busy_o and in_stream_i.ready may assert at t+1.
- Data latency: 1 cycle, from input handshake to out_stream_o.valid.
- Sustained throughput is 1 beat/cycle when out_stream_o.ready is held high.
- Backpressure:
  - out_stream_o.valid, data, strb and last_o stay stable while ready=0;
  - valid never drops without a handshake.
- Completion:
  - done_o asserts the cycle after the final output handshake;
  - busy_o deasserts in the same cycle done_o asserts;
  - length 0: start at t → done_o at t+1, busy_o high only at t+1 is not required (busy_o stays 0).
- A new start_i is accepted in the cycle after done_o at the earliest.
- Simultaneous input and output handshake in the same cycle: the register is replaced with no bubble.

## Test plan
- length_i=32, ready always 1:
  - two beats pass unchanged, strb all-ones;
  - last_o only on the second beat;
  - done_o exactly one cycle after the second output handshake.
- length_i=20:
  - second beat lanes 0–3 carry input data;
  - lanes 4–15 = 16'hFF80;
  - strb = 32'h000000FF, last_o=1.
- length_i=0: no in_stream_i.ready assertion; done_o pulses at t+1; busy_o stays 0.
- length_i=64 with random out_stream_o.ready (50%):
  - output data/strb/last stable under stall;
  - 4 beats delivered in order with no loss or duplication.
- start_i pulsed mid-RUN with length_i=1:
  - ignored; the original job completes with its original beat count.
- rst_i asserted after the 2nd of 4 beats:
  - next cycle valid=0, busy_o=0, no done_o;
  - new job length_i=16 then completes normally with one last beat.
